// File: rtl/serial_panel_io.sv
// serial_panel_io
//   Drives a serial LED shift register and reads a serial DIP-switch shift
//   register over a shared shift clock. One transfer does the following:
//   parallel-load the DIP register, shift WIDTH bits in both directions
//   (MSB first), latch the LED word, then publish the captured DIP word.
//
// Ports
//   i_CLK       system clock
//   i_RST_N     asynchronous active-low reset
//   i_Start     transfer request; sampled only while idle
//   i_LED       LED pattern, captured when i_Start is accepted
//   o_Busy      high while a transfer is in progress
//   o_PSCLK     serial shift clock
//   o_LEDData   serial LED data, MSB first
//   o_LEDLatch  LED commit pulse (2*HALF_DIV cycles)
//   o_DIPLatch  DIP parallel-load pulse (2*HALF_DIV cycles)
//   i_DIPData   serial DIP data, MSB first
//   o_DIP       last complete DIP word
//   o_DIPValid  one-cycle pulse when o_DIP updates
module serial_panel_io #(
    parameter int WIDTH    = 8,
    parameter int HALF_DIV = 4
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_Start,
    input  logic [WIDTH-1:0] i_LED,
    output logic             o_Busy,
    output logic             o_PSCLK,
    output logic             o_LEDData,
    output logic             o_LEDLatch,
    output logic             o_DIPLatch,
    input  logic             i_DIPData,
    output logic [WIDTH-1:0] o_DIP,
    output logic             o_DIPValid
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [7:0]       presc_q;
    logic             phase_q;   // 0 = first half-period, 1 = second
    logic [BW-1:0]    bit_q;
    logic [WIDTH-1:0] led_sh_q;
    logic [WIDTH-1:0] dcap_q;
    logic             busy_q;
    logic             psclk_q;
    logic             led_data_q;
    logic             led_latch_q;
    logic             dip_latch_q;
    logic [WIDTH-1:0] dip_q;
    logic             dip_valid_q;
    logic             half_tick;

    assign half_tick = (presc_q == 8'(HALF_DIV - 1));

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            phase_q     <= 1'b0;
            bit_q       <= '0;
            led_sh_q    <= '0;
            dcap_q      <= '0;
            busy_q      <= 1'b0;
            psclk_q     <= 1'b0;
            led_data_q  <= 1'b0;
            led_latch_q <= 1'b0;
            dip_latch_q <= 1'b0;
            dip_q       <= '0;
            dip_valid_q <= 1'b0;
        end else begin
            dip_valid_q <= 1'b0;

            // Prescaler only runs while a timed phase is active.
            if (state_q == S_IDLE || state_q == S_DONE) begin
                presc_q <= '0;
                phase_q <= 1'b0;
            end else begin
                presc_q <= half_tick ? '0 : presc_q + 8'd1;
                if (half_tick) begin
                    phase_q <= ~phase_q;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (i_Start) begin
                        led_sh_q    <= i_LED;
                        bit_q       <= '0;
                        busy_q      <= 1'b1;
                        dip_latch_q <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (half_tick && phase_q) begin
                        dip_latch_q <= 1'b0;
                        led_data_q  <= led_sh_q[WIDTH-1];
                        led_sh_q    <= led_sh_q << 1;
                        state_q     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (half_tick) begin
                        if (!phase_q) begin
                            // Rising shift clock: sample DIP bit at the same edge.
                            psclk_q <= 1'b1;
                            dcap_q  <= {dcap_q[WIDTH-2:0], i_DIPData};
                        end else begin
                            psclk_q <= 1'b0;
                            if (bit_q == BW'(WIDTH - 1)) begin
                                led_data_q  <= 1'b0;
                                led_latch_q <= 1'b1;
                                state_q     <= S_LATCH;
                            end else begin
                                bit_q      <= bit_q + 1'b1;
                                led_data_q <= led_sh_q[WIDTH-1];
                                led_sh_q   <= led_sh_q << 1;
                            end
                        end
                    end
                end
                S_LATCH: begin
                    if (half_tick && phase_q) begin
                        led_latch_q <= 1'b0;
                        dip_q       <= dcap_q;
                        dip_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Busy     = busy_q;
    assign o_PSCLK    = psclk_q;
    assign o_LEDData  = led_data_q;
    assign o_LEDLatch = led_latch_q;
    assign o_DIPLatch = dip_latch_q;
    assign o_DIP      = dip_q;
    assign o_DIPValid = dip_valid_q;

endmodule

// File: tb/tb_serial_panel_io.sv
// tb_serial_panel_io
//   Two instances: the default configuration (HALF_DIV=4, WIDTH=8) and a
//   fast one (HALF_DIV=1, WIDTH=4). A reference model expresses the expected
//   waveform as a function of the number of cycles since acceptance. A
//   simple serial DIP-register model feeds i_DIPData.
module tb_serial_panel_io;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start [2];
    logic [7:0] led   [2];
    logic [7:0] dipw  [2];
    logic       din   [2];

    logic       busy0, ps0, ld0, ll0, dl0, v0;
    logic [7:0] odip0;
    logic       busy1, ps1, ld1, ll1, dl1, v1;
    logic [3:0] odip1;

    serial_panel_io #(.WIDTH(8), .HALF_DIV(4)) u_dut0 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_Start(start[0]), .i_LED(led[0]),
        .o_Busy(busy0), .o_PSCLK(ps0), .o_LEDData(ld0), .o_LEDLatch(ll0),
        .o_DIPLatch(dl0), .i_DIPData(din[0]), .o_DIP(odip0), .o_DIPValid(v0)
    );

    serial_panel_io #(.WIDTH(4), .HALF_DIV(1)) u_dut1 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_Start(start[1]), .i_LED(led[1][3:0]),
        .o_Busy(busy1), .o_PSCLK(ps1), .o_LEDData(ld1), .o_LEDLatch(ll1),
        .o_DIPLatch(dl1), .i_DIPData(din[1]), .o_DIP(odip1), .o_DIPValid(v1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: n = cycles since acceptance (0 = idle).
    int         n     [2];
    logic [7:0] mled  [2];
    logic [7:0] mdip  [2];
    logic [7:0] edip  [2];
    logic [7:0] dreg  [2];
    logic       pprev [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int hdv(input int id);
        return (id == 0) ? 4 : 1;
    endfunction

    function automatic int wv(input int id);
        return (id == 0) ? 8 : 4;
    endfunction

    function automatic logic [7:0] wmask(input int id);
        return (id == 0) ? 8'hFF : 8'h0F;
    endfunction

    // {busy, psclk, leddata, ledlatch, diplatch, valid}
    function automatic logic [5:0] exp_out(input int id);
        int t  = 2 * hdv(id);
        int w  = wv(id);
        int nn = n[id];
        int m, k;
        logic [7:0] lv;
        logic busy = 1'b0, ps = 1'b0, ld = 1'b0, ll = 1'b0, dl = 1'b0, v = 1'b0;
        lv = mled[id];
        if (nn >= 1 && nn <= t) begin
            busy = 1'b1; dl = 1'b1;
        end else if (nn > t && nn <= t * (w + 1)) begin
            m = nn - t - 1;
            k = m / t;
            busy = 1'b1;
            ps = ((m % t) >= hdv(id));
            ld = lv[w - 1 - k];
        end else if (nn > t * (w + 1) && nn <= t * (w + 2)) begin
            busy = 1'b1; ll = 1'b1;
        end else if (nn == t * (w + 2) + 1) begin
            busy = 1'b1; v = 1'b1;
        end
        return {busy, ps, ld, ll, dl, v};
    endfunction

    function automatic logic [5:0] act_out(input int id);
        return (id == 0) ? {busy0, ps0, ld0, ll0, dl0, v0}
                         : {busy1, ps1, ld1, ll1, dl1, v1};
    endfunction

    function automatic logic [7:0] act_dip(input int id);
        return (id == 0) ? odip0 : {4'h0, odip1};
    endfunction

    task automatic model_step(input int id);
        int done_n = 2 * hdv(id) * (wv(id) + 2) + 1;
        if (!rst_n) begin
            n[id]    = 0;
            edip[id] = '0;
        end else if (n[id] == 0) begin
            if (start[id]) begin
                n[id]    = 1;
                mled[id] = led[id] & wmask(id);
                mdip[id] = dipw[id] & wmask(id);
            end
        end else begin
            n[id]++;
            if (n[id] > done_n) n[id] = 0;
        end
        if (n[id] == done_n) edip[id] = mdip[id];
    endtask

    // External DIP shift register: parallel load while latched, shift on PSCLK rise.
    task automatic dip_device(input int id);
        logic [5:0] o;
        logic [7:0] r;
        o = act_out(id);
        if (o[1]) dreg[id] = dipw[id];
        else if (o[4] && !pprev[id]) dreg[id] = dreg[id] << 1;
        pprev[id] = o[4];
        r = dreg[id];
        din[id] = r[wv(id) - 1];
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        for (int id = 0; id < 2; id++) begin
            model_step(id);
            check_eq($sformatf("out%0d_n%0d", id, n[id]), 32'(act_out(id)), 32'(exp_out(id)));
            check_eq($sformatf("dip%0d_n%0d", id, n[id]), 32'(act_dip(id)), 32'(edip[id]));
        end
        for (int id = 0; id < 2; id++) dip_device(id);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        for (int id = 0; id < 2; id++) begin
            check_eq($sformatf("rst_out%0d", id), 32'(act_out(id)), 32'd0);
            check_eq($sformatf("rst_dip%0d", id), 32'(act_dip(id)), 32'd0);
        end
        repeat (3) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int id = 0; id < 2; id++) begin
            start[id] = 1'b1;   // must be ignored while in reset
            n[id] = 0; mled[id] = '0; mdip[id] = '0; edip[id] = '0;
            dreg[id] = '0; pprev[id] = 1'b0; din[id] = 1'b0;
        end
        led[0] = 8'hA5; dipw[0] = 8'h3C;
        led[1] = 8'h09; dipw[1] = 8'h06;
        repeat (3) cycle();

        // Back-to-back transfers with i_Start held; LED changes mid-transfer.
        rst_n = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            if (c == 20) led[0] = 8'hFF;
            cycle();
        end

        // Drain, then one transfer aborted by reset around t+40, then a clean one.
        start[0] = 1'b0; start[1] = 1'b0;
        for (int c = 0; c < 200 && (n[0] != 0 || n[1] != 0); c++) cycle();
        check_eq("drain_idle", 32'(n[0] + n[1]), 32'd0);
        led[0] = 8'hA5; dipw[0] = 8'h3C;
        start[0] = 1'b1; start[1] = 1'b1;
        cycle();
        start[0] = 1'b0; start[1] = 1'b0;
        repeat (39) cycle();
        reset_pulse();
        start[0] = 1'b1; start[1] = 1'b1;
        cycle();
        start[0] = 1'b0; start[1] = 1'b0;
        repeat (100) cycle();

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            for (int id = 0; id < 2; id++) begin
                start[id] = ($urandom_range(0, 3) == 0);
                led[id]   = 8'($urandom) & wmask(id);
                if (n[id] == 0 && $urandom_range(0, 3) == 0)
                    dipw[id] = 8'($urandom) & wmask(id);
            end
            if ($urandom_range(0, 399) == 0) reset_pulse();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
